// File: rtl/writebacker.sv
// Writeback stage: latches the executer's result, extracts and extends load data,
// commits it to the integer register file and serves bypassed read ports.
module writebacker #(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  parameter  int RETIRE_W  = 64,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  input  logic                STALL,
  input  logic [AW-1:0]       IN_RD,
  input  logic                IN_REG_WRITE,
  input  logic                IN_MEM_TO_REG,
  input  logic [2:0]          IN_LOAD_FUNCT3,
  input  logic [1:0]          IN_BYTE_OFFSET,
  input  logic [31:0]         IN_PC,
  input  logic [XLEN-1:0]     EXEC_RD,
  input  logic [XLEN-1:0]     MEMORY_OUT,
  input  logic [AW-1:0]       RS1_ADDR,
  input  logic [AW-1:0]       RS2_ADDR,
  output logic [XLEN-1:0]     RS1_VAL,
  output logic [XLEN-1:0]     RS2_VAL,
  output logic [XLEN-1:0]     FORWARDED_VAL,
  output logic [AW-1:0]       FWD_RD,
  output logic                FWD_VALID,
  output logic [31:0]         WB_PC,
  output logic [RETIRE_W-1:0] RETIRED
);

  logic                r_valid;
  logic [AW-1:0]       r_rd;
  logic                r_reg_write;
  logic                r_mem_to_reg;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic [31:0]         r_pc;
  logic [XLEN-1:0]     r_exec;
  logic [XLEN-1:0]     r_mem;
  logic [XLEN-1:0]     r_regs [REG_COUNT];
  logic [RETIRE_W-1:0] r_retired;

  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [XLEN-1:0]     w_load;
  logic [XLEN-1:0]     w_wb;
  logic                w_commit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid      <= 1'b0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_pc         <= '0;
      r_exec       <= '0;
      r_mem        <= '0;
    end else if (!STALL) begin
      r_valid      <= IN_VALID;
      r_rd         <= IN_RD;
      r_reg_write  <= IN_REG_WRITE;
      r_mem_to_reg <= IN_MEM_TO_REG;
      r_funct3     <= IN_LOAD_FUNCT3;
      r_off        <= IN_BYTE_OFFSET;
      r_pc         <= IN_PC;
      r_exec       <= EXEC_RD;
      r_mem        <= MEMORY_OUT;
    end
  end

  // Halfword selection uses only off[1]; a misaligned off[0] is ignored.
  always_comb begin
    w_byte = r_mem[{r_off, 3'b000} +: 8];
    w_half = r_mem[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = r_mem;
    endcase
    w_wb = r_mem_to_reg ? w_load : r_exec;
  end

  assign w_commit = r_valid & r_reg_write & ~STALL & (r_rd != '0);

  // x0 is never written because the commit condition excludes rd == 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_rd] <= w_wb;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_retired <= '0;
    end else if (r_valid && !STALL) begin
      r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  // Write-first bypass: a read of the register being committed sees the new value.
  always_comb begin
    RS1_VAL = r_regs[RS1_ADDR];
    if (RS1_ADDR == '0) begin
      RS1_VAL = '0;
    end else if (w_commit && (RS1_ADDR == r_rd)) begin
      RS1_VAL = w_wb;
    end
    RS2_VAL = r_regs[RS2_ADDR];
    if (RS2_ADDR == '0) begin
      RS2_VAL = '0;
    end else if (w_commit && (RS2_ADDR == r_rd)) begin
      RS2_VAL = w_wb;
    end
  end

  assign FORWARDED_VAL = w_wb;
  assign FWD_RD        = r_rd;
  assign FWD_VALID     = r_valid & r_reg_write & (r_rd != '0);
  assign WB_PC         = r_pc;
  assign RETIRED       = r_retired;

endmodule

// File: tb/tb_writebacker.sv
// Bench for writebacker: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the stage and register file.
module tb_writebacker;

  logic        CLK = 1'b0;
  logic        RST, IN_VALID, STALL, IN_REG_WRITE, IN_MEM_TO_REG;
  logic [4:0]  IN_RD, RS1_ADDR, RS2_ADDR, FWD_RD;
  logic [2:0]  IN_LOAD_FUNCT3;
  logic [1:0]  IN_BYTE_OFFSET;
  logic [31:0] IN_PC, EXEC_RD, MEMORY_OUT, RS1_VAL, RS2_VAL, FORWARDED_VAL, WB_PC;
  logic        FWD_VALID;
  logic [63:0] RETIRED;

  always #5 CLK = ~CLK;

  writebacker dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .STALL(STALL), .IN_RD(IN_RD),
    .IN_REG_WRITE(IN_REG_WRITE), .IN_MEM_TO_REG(IN_MEM_TO_REG),
    .IN_LOAD_FUNCT3(IN_LOAD_FUNCT3), .IN_BYTE_OFFSET(IN_BYTE_OFFSET), .IN_PC(IN_PC),
    .EXEC_RD(EXEC_RD), .MEMORY_OUT(MEMORY_OUT), .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .FORWARDED_VAL(FORWARDED_VAL), .FWD_RD(FWD_RD),
    .FWD_VALID(FWD_VALID), .WB_PC(WB_PC), .RETIRED(RETIRED)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  // Reference model state
  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_pc, m_exec, m_mem;
  logic [31:0] m_regs [32];
  logic [63:0] m_ret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_f3 = 0; m_off = 0;
    m_pc = 0; m_exec = 0; m_mem = 0; m_ret = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  function automatic logic [31:0] model_wb();
    int unsigned sh;
    logic [31:0] w;
    if (!m_m2r) return m_exec;
    case (m_f3)
      3'd0, 3'd4: begin
        sh = m_off * 8;
        w = (m_mem >> sh) & 32'hFF;
        if (m_f3 == 3'd0 && w >= 32'h80) w = w + 32'hFFFFFF00;
        return w;
      end
      3'd1, 3'd5: begin
        sh = (m_off / 2) * 16;
        w = (m_mem >> sh) & 32'hFFFF;
        if (m_f3 == 3'd1 && w >= 32'h8000) w = w + 32'hFFFF0000;
        return w;
      end
      default: return m_mem;
    endcase
  endfunction

  function automatic logic model_commit(input logic st);
    return m_valid && m_rw && !st && (m_rd != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic st);
    if (a == 0) return 0;
    if (model_commit(st) && a == m_rd) return model_wb();
    return m_regs[a];
  endfunction

  // One clock: drive at negedge, check combinational view, advance model at posedge.
  task automatic cyc(input logic rst, input logic st, input logic v, input logic rw,
                     input logic m2r, input logic [4:0] rd, input logic [2:0] f3,
                     input logic [1:0] off, input logic [31:0] pc, input logic [31:0] ex,
                     input logic [31:0] mem, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] wb;
    RST = rst; STALL = st; IN_VALID = v; IN_REG_WRITE = rw; IN_MEM_TO_REG = m2r;
    IN_RD = rd; IN_LOAD_FUNCT3 = f3; IN_BYTE_OFFSET = off; IN_PC = pc;
    EXEC_RD = ex; MEMORY_OUT = mem; RS1_ADDR = a1; RS2_ADDR = a2;
    #1;
    check("rs1_val", RS1_VAL, model_read(a1, st));
    check("rs2_val", RS2_VAL, model_read(a2, st));
    check("fwd_val", FORWARDED_VAL, model_wb());
    check("fwd_rd", FWD_RD, m_rd);
    check("fwd_valid", FWD_VALID, m_valid && m_rw && (m_rd != 0));
    check("wb_pc", WB_PC, m_pc);
    check("retired", RETIRED, m_ret);
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else begin
      wb = model_wb();
      if (model_commit(st)) m_regs[m_rd] = wb;
      if (m_valid && !st) m_ret = m_ret + 1;
      if (!st) begin
        m_valid = v; m_rw = rw; m_m2r = m2r; m_rd = rd; m_f3 = f3;
        m_off = off; m_pc = pc; m_exec = ex; m_mem = mem;
      end
    end
    @(negedge CLK);
    n_txn++;
    $display("txn %0d rst=%0b stall=%0b v=%0b rd=%0d wb=%h ret=%0d",
             n_txn, rst, st, v, rd, FORWARDED_VAL, RETIRED);
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    cyc(0, 0, 0, 0, 0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, a1, a2);
  endtask

  logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ld_off [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [31:0] ld_exp [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
  logic [63:0] ret_before;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1; STALL = 0; IN_VALID = 0; IN_REG_WRITE = 0; IN_MEM_TO_REG = 0;
    IN_RD = 0; IN_LOAD_FUNCT3 = 0; IN_BYTE_OFFSET = 0; IN_PC = 0;
    EXEC_RD = 0; MEMORY_OUT = 0; RS1_ADDR = 0; RS2_ADDR = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // Reset state: every register reads zero
    for (int i = 0; i < 16; i++) idle_read(5'(i), 5'(31 - i));

    // ALU write to x5, bypass then stored value
    cyc(0, 0, 1, 1, 0, 5'd5, 3'd0, 2'd0, 32'h100, 32'h12345678, 32'h0, 5'd0, 5'd0);
    check("alu_fwd", FORWARDED_VAL, 32'h12345678);
    check("alu_fwd_valid", FWD_VALID, 1'b1);
    idle_read(5'd5, 5'd0);
    check("alu_retired", RETIRED, 64'd1);
    idle_read(5'd5, 5'd5);

    // Load extraction
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 1, 1, 5'd3, ld_f3[k], ld_off[k], 32'h200 + 32'(k * 4),
          32'h55555555, 32'h80FF7F01, 5'd3, 5'd1);
      check($sformatf("load%0d", k), FORWARDED_VAL, ld_exp[k]);
    end
    idle_read(5'd3, 5'd3);

    // Write to x0 is dropped but still retires
    ret_before = m_ret;
    cyc(0, 0, 1, 1, 0, 5'd0, 3'd0, 2'd0, 32'h300, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0);
    check("x0_fwd_valid", FWD_VALID, 1'b0);
    idle_read(5'd0, 5'd0);
    check("x0_retired", RETIRED, ret_before + 1);

    // Stall with a pending write to x7
    cyc(0, 0, 1, 1, 0, 5'd7, 3'd0, 2'd0, 32'h400, 32'hAA, 32'h0, 5'd7, 5'd0);
    ret_before = m_ret;
    repeat (3) cyc(0, 1, 1, 1, 0, 5'd9, 3'd0, 2'd0, 32'h404, 32'hBB, 32'h0, 5'd7, 5'd7);
    check("stall_retired", RETIRED, ret_before);
    check("stall_fwd_valid", FWD_VALID, 1'b1);
    idle_read(5'd7, 5'd0);
    check("release_retired", RETIRED, ret_before + 1);
    idle_read(5'd7, 5'd9);

    // Reset while a valid write sits in the stage
    cyc(0, 0, 1, 1, 0, 5'd9, 3'd0, 2'd0, 32'h500, 32'h5A5A5A5A, 32'h0, 5'd9, 5'd0);
    cyc(1, 0, 1, 1, 0, 5'd10, 3'd0, 2'd0, 32'h504, 32'h77, 32'h0, 5'd9, 5'd0);
    check("rst_fwd_valid", FWD_VALID, 1'b0);
    for (int i = 0; i < 16; i++) idle_read(5'(i), 5'(31 - i));

    // Randomized traffic with a small rd range to provoke hazards
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
          ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 7)),
          3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
          5'($urandom_range(0, 7)), 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
